// File: rtl/data_bus_uart_tx.sv
// data_bus_uart_tx: memory-mapped 8N1 UART transmitter on the datapath data bus.
//
// Bytes written to TXDATA go into a small FIFO. A serializer drains it as
// start/8 data (LSB first)/stop frames on uart_tx. STATUS and BAUDDIV are
// readable with the datapath's stalled LW. The stall cycle holds the address
// with mode idle, so rd_q already holds the value when the read cycle arrives.
//
// Bus protocol: there is no valid/ready pair. data_bus_mode qualifies each
// cycle (00 idle, 01 read, 10 write, 11 idle). A write to a hit address
// takes effect on that rising edge and is never refused; a TXDATA push into
// a full FIFO is dropped and recorded in STATUS.overflow. A read is answered
// in the same cycle from rd_q, which reloads every edge from the current
// address.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-low
//   data_bus_data  bidirectional data; driven only on a read hit
//   data_bus_addr  byte address (window = BASE_ADDR[31:4], reg = addr[3:2])
//   data_bus_mode  bus cycle type
//   uart_tx        registered serial line, idles high
//   tx_empty       registered: FIFO empty and serializer idle
//   state_dbg      current serializer state (0 IDLE, 1 START, 2 DATA, 3 STOP)
module data_bus_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          FIFO_DEPTH  = 4,   // power of two, >= 2
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        reset,
    inout  wire  [31:0] data_bus_data,
    input  logic [31:0] data_bus_addr,
    input  logic [1:0]  data_bus_mode,
    output logic        uart_tx,
    output logic        tx_empty,
    output logic [1:0]  state_dbg
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] MODE_READ   = 2'b01;
    localparam logic [1:0] MODE_WRITE  = 2'b10;
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // ---------------- bus decode ----------------
    logic       hit;
    logic [1:0] reg_sel;
    logic       wr_en;
    logic       push_req;
    logic       push;
    logic       pop;

    assign hit      = (data_bus_addr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel  = data_bus_addr[3:2];
    assign wr_en    = hit && (data_bus_mode == MODE_WRITE);
    assign push_req = wr_en && (reg_sel == REG_TXDATA);

    // ---------------- FIFO ----------------
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fifo_full, fifo_empty;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    // Fullness is judged on the registered count, so a push into a full FIFO
    // is dropped even when the serializer pops on the same edge.
    assign push       = push_req && !fifo_full;

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= data_bus_data[7:0];
    end

    // ---------------- control registers ----------------
    logic [15:0] div_reg_q;
    logic        ovf_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_reg_q <= DEFAULT_DIV;
            ovf_q     <= 1'b0;
        end else begin
            if (wr_en && (reg_sel == REG_BAUDDIV)) div_reg_q <= data_bus_data[15:0];
            if (push_req && fifo_full)
                ovf_q <= 1'b1;
            else if (wr_en && (reg_sel == REG_STATUS) && data_bus_data[3])
                ovf_q <= 1'b0;
        end
    end

    // ---------------- serializer FSM ----------------
    state_t      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] div_q;
    logic [15:0] baud_cnt_q;
    logic [2:0]  bit_idx_q;
    logic        bit_done;
    logic        tx_q, tx_d;
    logic        tx_empty_q, tx_empty_d;

    assign bit_done = (baud_cnt_q == div_q);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state; pop is the transition that starts a frame
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: if (bit_done) state_d = ST_DATA;
            ST_DATA:  if (bit_done && (bit_idx_q == 3'd7)) state_d = ST_STOP;
            ST_STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;   // chain straight into the next frame
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state so the registered line
    // changes on the same edge as the state.
    always_comb begin
        shift_d = shift_q;
        if (pop)
            shift_d = fifo_mem[rd_ptr_q];
        else if ((state_q == ST_DATA) && bit_done)
            shift_d = {1'b0, shift_q[7:1]};

        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase

        tx_empty_d = (state_d == ST_IDLE) && (count_d == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q    <= '0;
            div_q      <= DEFAULT_DIV;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            tx_q       <= 1'b1;
            tx_empty_q <= 1'b1;
        end else begin
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            tx_empty_q <= tx_empty_d;
            // BAUDDIV is sampled once per frame so mid-frame writes wait.
            if (pop) div_q <= div_reg_q;
            if (pop || bit_done || (state_q == ST_IDLE))
                baud_cnt_q <= '0;
            else
                baud_cnt_q <= baud_cnt_q + 16'd1;
            if (state_q != ST_DATA)
                bit_idx_q <= '0;
            else if (bit_done)
                bit_idx_q <= bit_idx_q + 3'd1;
        end
    end

    assign uart_tx   = tx_q;
    assign tx_empty  = tx_empty_q;
    assign state_dbg = state_q;

    // ---------------- read path ----------------
    logic [31:0] rd_d, rd_q;
    logic [31:0] count_ext;

    assign count_ext = 32'(count_q);

    always_comb begin
        rd_d = '0;
        case (reg_sel)
            REG_STATUS: begin
                rd_d[0]    = (state_q != ST_IDLE);
                rd_d[1]    = fifo_full;
                rd_d[2]    = fifo_empty;
                rd_d[3]    = ovf_q;
                rd_d[11:8] = count_ext[3:0];
            end
            REG_BAUDDIV: rd_d[15:0] = div_reg_q;
            default:     rd_d = '0;
        endcase
    end

    // Loaded regardless of mode so the LW stall cycle primes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_q <= '0;
        else        rd_q <= rd_d;
    end

    assign data_bus_data = (hit && (data_bus_mode == MODE_READ)) ? rd_q : 32'bz;

    // Bus bits that are decoded but never consumed.
    logic unused_bits;
    assign unused_bits = ^{data_bus_data[31:16], data_bus_addr[1:0], count_ext[31:4]};

endmodule

// File: tb/tb_data_bus_uart_tx.sv
// Directed testbench for data_bus_uart_tx. Inputs change on the falling
// edge; outputs are sampled on the falling edge or 2 ns after it.
module tb_data_bus_uart_tx;

    localparam logic [31:0] BASE      = 32'h0001_0000;
    localparam logic [31:0] A_TXDATA  = BASE + 32'h0;
    localparam logic [31:0] A_STATUS  = BASE + 32'h4;
    localparam logic [31:0] A_BAUDDIV = BASE + 32'h8;
    localparam logic [31:0] A_RSVD    = BASE + 32'hC;
    localparam logic [31:0] RELEASED  = 32'hFFFF_FFFF;   // pulled-up, undriven bus

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_bus_addr;
    logic [1:0]  data_bus_mode;
    wire  [31:0] data_bus_data;
    logic        tb_drv_en;
    logic [31:0] tb_drv_data;
    logic        uart_tx;
    logic        tx_empty;
    logic [1:0]  state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];

    assign data_bus_data = tb_drv_en ? tb_drv_data : 32'bz;

    for (genvar i = 0; i < 32; i++) begin : g_pull
        pullup (data_bus_data[i]);
    end

    data_bus_uart_tx dut (
        .clk           (clk),
        .reset         (reset),
        .data_bus_data (data_bus_data),
        .data_bus_addr (data_bus_addr),
        .data_bus_mode (data_bus_mode),
        .uart_tx       (uart_tx),
        .tx_empty      (tx_empty),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic drive_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        data_bus_addr = addr;
        data_bus_mode = 2'b10;
        tb_drv_en     = 1'b1;
        tb_drv_data   = data;
    endtask

    task automatic drive_idle();
        @(negedge clk);
        data_bus_mode = 2'b00;
        tb_drv_en     = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        drive_write(addr, data);
        drive_idle();
    endtask

    // Stalled LW: one idle cycle with the address, then one read cycle.
    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [31:0] idle_val);
        @(negedge clk);
        data_bus_addr = addr;
        data_bus_mode = 2'b00;
        tb_drv_en     = 1'b0;
        #2 idle_val = data_bus_data;
        @(negedge clk);
        data_bus_mode = 2'b01;
        #2 data = data_bus_data;
        @(negedge clk);
        data_bus_mode = 2'b00;
    endtask

    // Serial-line scoreboard: checks every clock of each frame for the bytes
    // in exp_q, back to back, then tx_empty rising one cycle after the last
    // stop cycle. Starts at the first sample where uart_tx is low.
    task automatic check_frames(input int bits, input string tag);
        int budget;
        int n;
        logic [7:0] b;
        logic [9:0] sym;
        budget = 100;
        n      = exp_q.size();
        while (uart_tx !== 1'b0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        tests_run++;
        if (uart_tx !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s start_bit_timeout uart_tx=%b expected 0", tag, uart_tx);
            exp_q.delete();
            return;
        end
        for (int f = 0; f < n; f++) begin
            b   = exp_q.pop_front();
            sym = {1'b1, b, 1'b0};
            for (int s = 0; s < 10; s++) begin
                for (int c = 0; c < bits; c++) begin
                    if (!(f == 0 && s == 0 && c == 0)) @(negedge clk);
                    tests_run++;
                    if (uart_tx !== sym[s]) begin
                        tests_failed++;
                        $display("FAIL %s frame%0d(0x%02h) sym%0d cyc%0d uart_tx=%b expected %b",
                                 tag, f, b, s, c, uart_tx, sym[s]);
                    end
                end
            end
        end
        tests_run++;
        if (tx_empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s tx_empty_in_last_stop got=%b expected 0", tag, tx_empty);
        end
        @(negedge clk);
        tests_run++;
        if (tx_empty !== 1'b1 || uart_tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s after_frames tx_empty=%b uart_tx=%b expected 1 1", tag, tx_empty, uart_tx);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] d, iv;
        reset         = 1'b0;
        data_bus_addr = 32'h0;
        data_bus_mode = 2'b00;
        tb_drv_en     = 1'b0;
        tb_drv_data   = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (uart_tx !== 1'b1 || tx_empty !== 1'b1 || state_dbg !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs uart_tx=%b tx_empty=%b state=%0d expected 1 1 0",
                     uart_tx, tx_empty, state_dbg);
        end
        bus_read(A_STATUS, d, iv);
        tests_run++;
        if (d !== 32'h0000_0004 || iv !== RELEASED) begin
            tests_failed++;
            $display("FAIL reset_status got=%h idle=%h expected 00000004 ffffffff", d, iv);
        end
        bus_read(A_BAUDDIV, d, iv);
        tests_run++;
        if (d !== 32'd433) begin
            tests_failed++;
            $display("FAIL reset_bauddiv got=%0d expected 433", d);
        end
        bus_read(A_TXDATA, d, iv);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL read_txdata got=%h expected 00000000", d);
        end
        bus_read(A_RSVD, d, iv);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL read_reserved got=%h expected 00000000", d);
        end
        // Reads outside the window leave the bus released.
        bus_read(32'h0002_0004, d, iv);
        tests_run++;
        if (d !== RELEASED) begin
            tests_failed++;
            $display("FAIL miss_read_far got=%h expected ffffffff", d);
        end
        bus_read(BASE + 32'h10, d, iv);
        tests_run++;
        if (d !== RELEASED) begin
            tests_failed++;
            $display("FAIL miss_read_next_window got=%h expected ffffffff", d);
        end
        // Hit write with nobody driving: DUT must not drive either.
        @(negedge clk);
        data_bus_addr = A_RSVD;
        data_bus_mode = 2'b10;
        tb_drv_en     = 1'b0;
        #2;
        tests_run++;
        if (data_bus_data !== RELEASED) begin
            tests_failed++;
            $display("FAIL bus_during_write got=%h expected ffffffff", data_bus_data);
        end
        drive_idle();
        bus_read(A_BAUDDIV, d, iv);
        tests_run++;
        if (d !== 32'd433) begin
            tests_failed++;
            $display("FAIL reserved_write_ignored bauddiv=%0d expected 433", d);
        end
    endtask

    task automatic test_single_frame();
        logic [31:0] d, iv;
        bus_write(A_BAUDDIV, 32'd3);
        bus_read(A_BAUDDIV, d, iv);
        tests_run++;
        if (d !== 32'd3) begin
            tests_failed++;
            $display("FAIL bauddiv_readback got=%0d expected 3", d);
        end
        bus_write(A_TXDATA, 32'h0000_00A5);
        // Now in the cycle right after the write edge.
        tests_run++;
        if (uart_tx !== 1'b1 || tx_empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL a5_cycle0 uart_tx=%b tx_empty=%b expected 1 0", uart_tx, tx_empty);
        end
        @(negedge clk);
        tests_run++;
        if (uart_tx !== 1'b0) begin
            tests_failed++;
            $display("FAIL a5_start_latency uart_tx=%b expected 0", uart_tx);
        end
        exp_q.push_back(8'hA5);
        check_frames(4, "a5");
    endtask

    task automatic test_overflow();
        logic [31:0] d, iv;
        bus_write(A_BAUDDIV, 32'd3);
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        fork
            begin
                for (int i = 1; i <= 6; i++) drive_write(A_TXDATA, 32'(i));
                drive_idle();
                bus_read(A_STATUS, d, iv);
                tests_run++;
                if (d !== 32'h0000_040B) begin
                    tests_failed++;
                    $display("FAIL ovf_status got=%h expected 0000040b", d);
                end
                bus_write(A_STATUS, 32'h8);
                bus_read(A_STATUS, d, iv);
                tests_run++;
                if (d !== 32'h0000_0403) begin
                    tests_failed++;
                    $display("FAIL ovf_cleared got=%h expected 00000403", d);
                end
            end
            begin
                check_frames(4, "ovf");
            end
        join
    endtask

    task automatic test_stalled_lw();
        @(negedge clk);
        data_bus_addr = A_STATUS;
        data_bus_mode = 2'b00;
        #2;
        tests_run++;
        if (data_bus_data !== RELEASED) begin
            tests_failed++;
            $display("FAIL lw_stall_cycle got=%h expected ffffffff", data_bus_data);
        end
        @(negedge clk);
        data_bus_mode = 2'b01;
        #2;
        tests_run++;
        if (data_bus_data !== 32'h0000_0004) begin
            tests_failed++;
            $display("FAIL lw_read_cycle got=%h expected 00000004", data_bus_data);
        end
        @(negedge clk);
        data_bus_mode = 2'b00;
        #2;
        tests_run++;
        if (data_bus_data !== RELEASED) begin
            tests_failed++;
            $display("FAIL lw_after_read got=%h expected ffffffff", data_bus_data);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d, iv;
        int low_seen;
        bus_write(A_BAUDDIV, 32'd3);
        drive_write(A_TXDATA, 32'hFF);
        drive_write(A_TXDATA, 32'h00);
        drive_idle();
        repeat (8) @(negedge clk);
        tests_run++;
        if (state_dbg !== 2'd2 || uart_tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_in_data state=%0d uart_tx=%b expected 2 1", state_dbg, uart_tx);
        end
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if (uart_tx !== 1'b1 || tx_empty !== 1'b1 || state_dbg !== 2'd0) begin
            tests_failed++;
            $display("FAIL async_reset uart_tx=%b tx_empty=%b state=%0d expected 1 1 0",
                     uart_tx, tx_empty, state_dbg);
        end
        @(negedge clk);
        reset = 1'b1;
        bus_read(A_STATUS, d, iv);
        tests_run++;
        if (d !== 32'h0000_0004) begin
            tests_failed++;
            $display("FAIL post_reset_status got=%h expected 00000004", d);
        end
        // The queued 0x00 must have been discarded: the line never drops.
        low_seen = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) low_seen++;
        end
        tests_run++;
        if (low_seen != 0 || tx_empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL fifo_flushed low_cycles=%0d tx_empty=%b expected 0 1", low_seen, tx_empty);
        end
    endtask

    task automatic test_div_zero();
        bus_write(A_BAUDDIV, 32'd0);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        fork
            begin
                drive_write(A_TXDATA, 32'h3C);
                drive_write(A_TXDATA, 32'hC3);
                drive_idle();
            end
            begin
                check_frames(1, "div0");
            end
        join
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_single_frame();
        test_overflow();
        test_stalled_lw();
        test_reset_mid_frame();
        test_div_zero();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
